rx_training_sequencer: RTL and testbench

- Controls the lane receive datapath during link training.
- Drives the receiver's ordered-set select code (d_sel), lane enable and data/ordered-set flag.
- Steps through the four training ordered sets for the selected generation:
  - Gen2/3: SLOS1, SLOS2, TS1, TS2.
  - Gen4: TS1, TS2, TS3, TS4.
- Counts per-lane detections from the receiver before each step, then switches the receiver to transport data mode.
- Sits between the LTSSM (start/abort/gen4) and the lane receive datapath.

---
 rtl/rx_training_pkg.sv | 27 ++
 rtl/rx_training_sequencer_os_match_counter.sv | 29 ++
 rtl/rx_training_sequencer.sv | 152 +++++++++++++++
 tb/tb_rx_training_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_training_pkg.sv
// Shared ordered-set codes and FSM state type for the lane receive training sequencer.
package rx_training_pkg;

  localparam logic [3:0] OS_SLOS1  = 4'd0;
  localparam logic [3:0] OS_SLOS2  = 4'd1;
  localparam logic [3:0] OS_TS1_G3 = 4'd2;
  localparam logic [3:0] OS_TS2_G3 = 4'd3;
  localparam logic [3:0] OS_TS1_G4 = 4'd4;
  localparam logic [3:0] OS_TS2_G4 = 4'd5;
  localparam logic [3:0] OS_TS3_G4 = 4'd6;
  localparam logic [3:0] OS_TS4_G4 = 4'd7;
  localparam logic [3:0] OS_DATA   = 4'd8;
  localparam logic [3:0] OS_NONE   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_DATA,
    ST_ERROR
  } rx_state_t;

  // Gen4 sequences live at codes 4..7, Gen2/3 at 0..3, so the base is just bit 2.
  function automatic logic [3:0] os_code(input logic gen4, input logic [1:0] stage);
    return {1'b0, gen4, stage};
  endfunction

endpackage

// File: rtl/rx_training_sequencer_os_match_counter.sv
// Per-lane saturating counter of detections of the currently expected ordered set.
module os_match_counter #(
  parameter int OS_REQ_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code,
  input  logic [3:0] expected,
  input  logic       clear,
  output logic       reached
);

  localparam logic [3:0] REQ = 4'(OS_REQ_CNT);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (code == expected && cnt_reg != REQ) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign reached = (cnt_reg == REQ);

endmodule

// File: rtl/rx_training_sequencer.sv
// Link-training sequencer: walks the receiver through four ordered-set stages,
// then switches it to transport data; aborts, times out per stage.
module rx_training_sequencer
  import rx_training_pkg::*;
#(
  parameter int OS_REQ_CNT     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gen4,
  input  logic [3:0] os_in_l0,
  input  logic [3:0] os_in_l1,
  output logic [3:0] d_sel,
  output logic       lane_rx_on,
  output logic       data_os,
  output logic [1:0] stage,
  output logic       stage_done,
  output logic       training_done,
  output logic       timeout_err
);

  localparam int                 NUM_LANES = 2;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  rx_state_t        state_reg;
  logic             gen4_reg;
  logic [TMO_W-1:0] timer_reg;
  logic [3:0]       d_sel_reg;
  logic             lane_rx_on_reg;
  logic             data_os_reg;
  logic [1:0]       stage_reg;
  logic             stage_done_reg;
  logic             training_done_reg;
  logic             timeout_err_reg;

  logic [3:0]           lane_code [NUM_LANES];
  logic [NUM_LANES-1:0] lane_reached;
  logic [3:0]           expected;
  logic                 in_train;
  logic                 complete;
  logic                 tmo_hit;
  logic                 cnt_clear;

  assign lane_code[0] = os_in_l0;
  assign lane_code[1] = os_in_l1;

  assign expected  = os_code(gen4_reg, stage_reg);
  assign in_train  = (state_reg == ST_TRAIN);
  assign complete  = in_train && (&lane_reached);
  // Completion takes priority over a timeout landing on the same cycle.
  assign tmo_hit   = in_train && !complete && (timer_reg == TMO_LAST);
  // Counters only run in TRAIN, so holding them clear elsewhere keeps stage entry clean.
  assign cnt_clear = abort || !in_train || complete || tmo_hit;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      os_match_counter #(
        .OS_REQ_CNT(OS_REQ_CNT)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .code    (lane_code[gi]),
        .expected(expected),
        .clear   (cnt_clear),
        .reached (lane_reached[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      gen4_reg          <= 1'b0;
      timer_reg         <= '0;
      d_sel_reg         <= OS_NONE;
      lane_rx_on_reg    <= 1'b0;
      data_os_reg       <= 1'b0;
      stage_reg         <= 2'd0;
      stage_done_reg    <= 1'b0;
      training_done_reg <= 1'b0;
      timeout_err_reg   <= 1'b0;
    end else begin
      stage_done_reg <= 1'b0;
      if (abort) begin
        state_reg         <= ST_IDLE;
        gen4_reg          <= 1'b0;
        timer_reg         <= '0;
        d_sel_reg         <= OS_NONE;
        lane_rx_on_reg    <= 1'b0;
        data_os_reg       <= 1'b0;
        stage_reg         <= 2'd0;
        training_done_reg <= 1'b0;
        timeout_err_reg   <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_ERROR: begin
            if (start) begin
              state_reg         <= ST_TRAIN;
              gen4_reg          <= gen4;
              timer_reg         <= '0;
              d_sel_reg         <= os_code(gen4, 2'd0);
              lane_rx_on_reg    <= 1'b1;
              data_os_reg       <= 1'b0;
              stage_reg         <= 2'd0;
              training_done_reg <= 1'b0;
              timeout_err_reg   <= 1'b0;
            end
          end
          ST_TRAIN: begin
            if (complete) begin
              stage_done_reg <= 1'b1;
              timer_reg      <= '0;
              if (stage_reg == 2'd3) begin
                state_reg         <= ST_DATA;
                d_sel_reg         <= OS_DATA;
                data_os_reg       <= 1'b1;
                training_done_reg <= 1'b1;
              end else begin
                stage_reg <= stage_reg + 2'd1;
                d_sel_reg <= os_code(gen4_reg, stage_reg + 2'd1);
              end
            end else if (tmo_hit) begin
              state_reg       <= ST_ERROR;
              timer_reg       <= '0;
              timeout_err_reg <= 1'b1;
              lane_rx_on_reg  <= 1'b0;
              d_sel_reg       <= OS_NONE;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          default: begin
            // DATA holds its outputs until abort or reset.
          end
        endcase
      end
    end
  end

  assign d_sel         = d_sel_reg;
  assign lane_rx_on    = lane_rx_on_reg;
  assign data_os       = data_os_reg;
  assign stage         = stage_reg;
  assign stage_done    = stage_done_reg;
  assign training_done = training_done_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_rx_training_sequencer.sv
// Randomised scoreboard bench for rx_training_sequencer: the driver predicts each
// stage outcome from per-lane detection counts, a monitor checks DUT events.
module tb_rx_training_sequencer;

  localparam int REQ     = 2;
  localparam int T       = 64;
  localparam int EV_DONE = 0;
  localparam int EV_TMO  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       gen4;
  logic [3:0] os_in_l0;
  logic [3:0] os_in_l1;
  logic [3:0] d_sel;
  logic       lane_rx_on;
  logic       data_os;
  logic [1:0] stage;
  logic       stage_done;
  logic       training_done;
  logic       timeout_err;

  always #5 clk = ~clk;

  rx_training_sequencer #(
    .OS_REQ_CNT    (REQ),
    .TIMEOUT_CYCLES(T),
    .TMO_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .gen4         (gen4),
    .os_in_l0     (os_in_l0),
    .os_in_l1     (os_in_l1),
    .d_sel        (d_sel),
    .lane_rx_on   (lane_rx_on),
    .data_os      (data_os),
    .stage        (stage),
    .stage_done   (stage_done),
    .training_done(training_done),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] d_sel;
    logic [1:0] stage;
    logic       fin;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_e;
  int   cyc      = 0;
  int   n_pass   = 0;
  int   n_total  = 0;
  logic prev_tmo = 1'b0;
  int   modes [4];
  bit   reached;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] noise(input logic [3:0] exp);
    int v;
    v = int'($urandom_range(0, 8));
    if (v >= int'(exp)) v++;
    return 4'(v);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a stage completion or a timeout.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("event_missing_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (stage_done) begin
        if (sb.size() == 0) begin
          check("unexpected_stage_done", int'(stage_done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", EV_DONE, mon_e.kind);
          check("done_cycle", cyc, mon_e.cyc);
          check("done_d_sel", int'(d_sel), int'(mon_e.d_sel));
          check("done_stage", int'(stage), int'(mon_e.stage));
          check("done_training_done", int'(training_done), int'(mon_e.fin));
          check("done_data_os", int'(data_os), int'(mon_e.fin));
          check("done_lane_rx_on", int'(lane_rx_on), 1);
          $display("txn stage_done cyc=%0d stage=%0d d_sel=%0d training_done=%0d",
                   cyc, stage, d_sel, training_done);
        end
      end
      if (timeout_err && !prev_tmo) begin
        if (sb.size() == 0) begin
          check("unexpected_timeout", int'(timeout_err), 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", EV_TMO, mon_e.kind);
          check("tmo_cycle", cyc, mon_e.cyc);
          check("tmo_d_sel", int'(d_sel), int'(mon_e.d_sel));
          check("tmo_stage", int'(stage), int'(mon_e.stage));
          check("tmo_lane_rx_on", int'(lane_rx_on), 0);
          $display("txn timeout cyc=%0d stage=%0d d_sel=%0d", cyc, stage, d_sel);
        end
      end
      prev_tmo = timeout_err;
    end
  end

  // mode 0 random hits, 1 no hits, 2 hits just before timeout, 3 lane1 20 cycles late, 4 abort+start
  task automatic run_stage(input logic g, input int s, input int mode, output bit ok);
    logic [3:0] exp;
    int         m0;
    int         m1;
    bit         hit0;
    bit         hit1;
    ev_t        e;
    exp = 4'((g ? 4 : 0) + s);
    m0  = 0;
    m1  = 0;
    ok  = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (mode == 4 && k == 5) begin
        abort = 1'b1; start = 1'b1;
        os_in_l0 = noise(exp); os_in_l1 = noise(exp);
        step();
        abort = 1'b0; start = 1'b0;
        $display("txn abort+start stage=%0d cyc=%0d", s, cyc);
        return;
      end
      if ((m0 >= REQ && m1 >= REQ) || k == T - 1) begin
        e.cyc = cyc + 1;
        if (m0 >= REQ && m1 >= REQ) begin
          e.kind  = EV_DONE;
          e.stage = 2'((s == 3) ? 3 : s + 1);
          e.d_sel = (s == 3) ? 4'd8 : 4'((g ? 4 : 0) + s + 1);
          e.fin   = (s == 3);
          ok      = 1'b1;
        end else begin
          e.kind  = EV_TMO;
          e.stage = 2'(s);
          e.d_sel = 4'd9;
          e.fin   = 1'b0;
        end
        sb.push_back(e);
        os_in_l0 = ($urandom_range(0, 1) == 1) ? exp : noise(exp);
        os_in_l1 = ($urandom_range(0, 1) == 1) ? exp : noise(exp);
        start    = 1'b0;
        step();
        return;
      end
      case (mode)
        0: begin hit0 = ($urandom_range(0, 2) == 0); hit1 = ($urandom_range(0, 2) == 0); end
        2: begin hit0 = (k >= T - 1 - REQ); hit1 = (k >= T - 1 - REQ); end
        3: begin hit0 = (k >= 1 && k <= REQ); hit1 = (k >= 21 && k <= 20 + REQ); end
        default: begin hit0 = 1'b0; hit1 = 1'b0; end
      endcase
      os_in_l0 = hit0 ? exp : noise(exp);
      os_in_l1 = hit1 ? exp : noise(exp);
      if (hit0) m0++;
      if (hit1) m1++;
      start = ($urandom_range(0, 15) == 0);
      step();
    end
  endtask

  task automatic run_training(input logic g, output bit done);
    bit ok;
    done = 1'b0;
    abort = 1'b0; start = 1'b1; gen4 = g;
    os_in_l0 = 4'd9; os_in_l1 = 4'd9;
    step();
    start = 1'b0;
    gen4  = 1'($urandom_range(0, 1));
    $display("txn start gen4=%0d cyc=%0d modes=%0d,%0d,%0d,%0d",
             g, cyc, modes[0], modes[1], modes[2], modes[3]);
    check("start_d_sel", int'(d_sel), g ? 4 : 0);
    check("start_lane_rx_on", int'(lane_rx_on), 1);
    check("start_stage", int'(stage), 0);
    check("start_timeout_err", int'(timeout_err), 0);
    for (int s = 0; s < 4; s++) begin
      run_stage(g, s, modes[s], ok);
      if (!ok) return;
    end
    done = 1'b1;
    os_in_l0 = 4'd9; os_in_l1 = 4'd9; start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_d_sel"}, int'(d_sel), 9);
    check({tag, "_stage"}, int'(stage), 0);
    check({tag, "_lane_rx_on"}, int'(lane_rx_on), 0);
    check({tag, "_data_os"}, int'(data_os), 0);
    check({tag, "_stage_done"}, int'(stage_done), 0);
    check({tag, "_training_done"}, int'(training_done), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    $display("txn abort cyc=%0d", cyc);
    check_idle("abort");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; gen4 = 1'b0;
    os_in_l0 = 4'd9; os_in_l1 = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    step();

    // Gen3 happy path, then DATA must ignore os_in and start.
    modes = '{0, 0, 0, 0};
    run_training(1'b0, reached);
    repeat (8) begin
      os_in_l0 = 4'($urandom_range(0, 9));
      os_in_l1 = 4'($urandom_range(0, 9));
      start    = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    check("data_d_sel", int'(d_sel), 8);
    check("data_lane_rx_on", int'(lane_rx_on), 1);
    check("data_data_os", int'(data_os), 1);
    check("data_training_done", int'(training_done), 1);

    // Asynchronous reset in the middle of DATA.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_idle("async_rst");
    step();
    rst = 1'b0;
    step();

    // Gen4 with lane 1 lagging lane 0 by 20 cycles.
    modes = '{3, 3, 3, 3};
    run_training(1'b1, reached);
    repeat (2) step();
    do_abort();

    // Timeout in stage 0, then restart from ERROR with completion on the timeout cycle.
    modes = '{1, 0, 0, 0};
    run_training(1'b0, reached);
    repeat (2) step();
    check("error_timeout_err", int'(timeout_err), 1);
    check("error_lane_rx_on", int'(lane_rx_on), 0);
    check("error_d_sel", int'(d_sel), 9);
    modes = '{2, 2, 0, 0};
    run_training(1'b1, reached);
    check("coincide_reached_data", int'(reached), 1);
    do_abort();

    // abort together with start in stage 2, then a fresh start.
    modes = '{0, 0, 4, 0};
    run_training(1'b0, reached);
    check_idle("abort_start");
    repeat (3) step();
    check("idle_hold_d_sel", int'(d_sel), 9);
    modes = '{0, 0, 0, 0};
    run_training(1'b0, reached);
    if (reached) do_abort();

    // Randomised rounds.
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < 4; s++) begin
        int v;
        v = int'($urandom_range(0, 9));
        modes[s] = (v <= 3) ? v + 1 : 0;
      end
      run_training(1'($urandom_range(0, 1)), reached);
      repeat (3) step();
      if (reached) do_abort();
    end

    repeat (5) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
